// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_W    : width of one lookahead group (one pipeline stage each)
//   num_groups : number of groups (and therefore stages) for an operand width
//   cla_pgc_t  : per-group bundle of bit propagates, generates and carries
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int GROUP_W = 4;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    typedef struct packed {
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] c;
    } cla_pgc_t;

endpackage

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// Purely combinational 4-bit carry-lookahead group. Every internal carry is a
// flat two-level sum of products of the bit generates/propagates and cin, so
// there is no ripple inside the group.
// Ports:
//   a, b  : 4-bit operand nibbles
//   cin   : carry into bit 0 of the group
//   s     : 4-bit sum
//   cout  : carry out of bit 3
//   pg    : group propagate (all four bits propagate)
//   gg    : group generate (the group produces a carry on its own)
// -----------------------------------------------------------------------------
module cla_group4
    import adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    cla_pgc_t w_pgc;

    // Bit-level propagate/generate plus the three lookahead carries, each
    // written directly in terms of cin rather than the previous carry.
    always_comb begin
        w_pgc      = '0;
        w_pgc.p    = a ^ b;
        w_pgc.g    = a & b;
        w_pgc.c[0] = cin;
        w_pgc.c[1] = w_pgc.g[0]
                   | (w_pgc.p[0] & cin);
        w_pgc.c[2] = w_pgc.g[1]
                   | (w_pgc.p[1] & w_pgc.g[0])
                   | (w_pgc.p[1] & w_pgc.p[0] & cin);
        w_pgc.c[3] = w_pgc.g[2]
                   | (w_pgc.p[2] & w_pgc.g[1])
                   | (w_pgc.p[2] & w_pgc.p[1] & w_pgc.g[0])
                   | (w_pgc.p[2] & w_pgc.p[1] & w_pgc.p[0] & cin);
    end

    assign pg   = &w_pgc.p;
    assign gg   = w_pgc.g[3]
                | (w_pgc.p[3] & w_pgc.g[2])
                | (w_pgc.p[3] & w_pgc.p[2] & w_pgc.g[1])
                | (w_pgc.p[3] & w_pgc.p[2] & w_pgc.p[1] & w_pgc.g[0]);
    assign cout = gg | (pg & cin);
    assign s    = w_pgc.p ^ w_pgc.c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// WIDTH-bit adder split into WIDTH/4 lookahead groups, one group per pipeline
// stage, with the inter-group carry registered between stages. Operands enter
// and results leave through valid/ready handshakes; empty stages are filled
// even while the output is stalled, so bubbles collapse.
// Optional feature macro: ADDER_SUB_EN adds the sub input and ovf output.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   A, B, Ci            : operands and carry in
//   out_valid/out_ready : result handshake
//   S, Co               : registered sum and carry out of bit WIDTH-1
//   sub, ovf            : subtract select / signed overflow (ADDER_SUB_EN)
// -----------------------------------------------------------------------------
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co
`ifdef ADDER_SUB_EN
    ,
    input  logic             sub,
    output logic             ovf
`endif
);

    localparam int NG = num_groups(WIDTH);

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_widthCheck
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    logic [NG-1:0]    r_valid;
    logic [NG-1:0]    r_carry;
    logic [WIDTH-1:0] r_sum [NG];
    logic [WIDTH-1:0] r_opA [NG];
    logic [WIDTH-1:0] r_opB [NG];

    logic [NG-1:0]    w_adv;
    logic [NG-1:0]    w_load;
    logic [NG-1:0]    w_fill;
    logic [NG-1:0]    w_carryNext;
    logic [WIDTH-1:0] w_sumNext [NG];
    logic [WIDTH-1:0] w_effB;
    logic             w_effCin;

    logic [3:0]       w_grpA    [NG];
    logic [3:0]       w_grpB    [NG];
    logic [3:0]       w_grpS    [NG];
    logic             w_grpCin  [NG];
    logic             w_grpCout [NG];
    logic             w_grpPg   [NG];
    logic             w_grpGg   [NG];

    // Subtraction is folded in at the entry: B is inverted and the carry
    // forced, and the inverted B is what travels down the skew registers.
`ifdef ADDER_SUB_EN
    assign w_effB   = B ^ {WIDTH{sub}};
    assign w_effCin = Ci | sub;
`else
    assign w_effB   = B;
    assign w_effCin = Ci;
`endif

    for (genvar k = 0; k < NG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_grpA[k]   = A[3:0];
            assign w_grpB[k]   = w_effB[3:0];
            assign w_grpCin[k] = w_effCin;
        end else begin : g_rest
            assign w_grpA[k]   = r_opA[k-1][4*k +: 4];
            assign w_grpB[k]   = r_opB[k-1][4*k +: 4];
            assign w_grpCin[k] = r_carry[k-1];
        end

        cla_group4 u_group (
            .a    (w_grpA[k]),
            .b    (w_grpB[k]),
            .cin  (w_grpCin[k]),
            .s    (w_grpS[k]),
            .cout (w_grpCout[k]),
            .pg   (w_grpPg[k]),
            .gg   (w_grpGg[k])
        );
    end

    // Advance chain runs from the output back to stage 0. A stage loads when
    // it is empty or its content moves on; it fills only when the stage
    // above actually hands a beat over (or a beat is accepted at stage 0).
    always_comb begin : p_handshake
        logic [NG-1:0] adv;
        adv        = '0;
        adv[NG-1]  = r_valid[NG-1] && out_ready;
        for (int k = NG - 2; k >= 0; k--) begin
            adv[k] = r_valid[k] && (!r_valid[k+1] || adv[k+1]);
        end
        w_adv     = adv;
        w_load    = ~r_valid | adv;
        w_fill    = '0;
        w_fill[0] = in_valid && w_load[0];
        for (int k = 1; k < NG; k++) begin
            w_fill[k] = adv[k-1];
        end
    end

    // Next sum image per stage: lower nibbles come from the stage above and
    // this stage's group result is spliced in on top. Inter-stage carries use
    // the group generate/propagate; the final stage keeps the group cout.
    always_comb begin
        w_sumNext[0]      = '0;
        w_sumNext[0][3:0] = w_grpS[0];
        for (int k = 1; k < NG; k++) begin
            w_sumNext[k]             = r_sum[k-1];
            w_sumNext[k][4*k +: 4]   = w_grpS[k];
        end
        w_carryNext = '0;
        for (int k = 0; k < NG - 1; k++) begin
            w_carryNext[k] = w_grpGg[k] | (w_grpPg[k] & w_grpCin[k]);
        end
        w_carryNext[NG-1] = w_grpCout[NG-1];
    end

    // Stage registers. Data only moves when a beat is handed over, so a
    // stalled last stage holds S/Co steady and an emptied stage keeps its
    // old (ignored) contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_carry <= '0;
            for (int k = 0; k < NG; k++) begin
                r_sum[k] <= '0;
                r_opA[k] <= '0;
                r_opB[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NG; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_fill[k];
                end
                if (w_fill[k]) begin
                    r_sum[k]   <= w_sumNext[k];
                    r_carry[k] <= w_carryNext[k];
                end
            end
            if (w_fill[0]) begin
                r_opA[0] <= A;
                r_opB[0] <= w_effB;
            end
            for (int k = 1; k < NG; k++) begin
                if (w_fill[k]) begin
                    r_opA[k] <= r_opA[k-1];
                    r_opB[k] <= r_opB[k-1];
                end
            end
        end
    end

`ifdef ADDER_SUB_EN
    logic r_ovf;
    logic w_ovfNext;

    assign w_ovfNext = (w_grpA[NG-1][3] == w_grpB[NG-1][3])
                    && (w_grpS[NG-1][3] != w_grpA[NG-1][3]);

    // Overflow is captured alongside the top nibble of the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_fill[NG-1]) begin
            r_ovf <= w_ovfNext;
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[NG-1];
    assign S         = r_sum[NG-1];
    assign Co        = r_carry[NG-1];

endmodule
